muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit, parametrised in operand width, sitting in the EX stage beside the single-cycle ALU. The ALU control unit still decodes base-ISA ops to `alusel`. When decode flags an M-extension op (funct7 = 0000001), this block takes the operands, stalls the pipeline through `busy`, and returns one registered result with a one-cycle `done` pulse. Divide-by-zero and signed overflow complete on a fast path.

---
 rtl/muldiv_unit_pkg.sv | 41 ++++
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit_iter_core.sv | 80 ++++++++
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared encodings for the RV32M multiply/divide unit. This package holds the
//   M-extension funct3/funct7 codes, the unit's FSM state encoding, and small
//   decode helpers that tell which operands an op treats as signed.
package muldiv_unit_pkg;

    // Tells decode that an R-type op belongs to the M extension.
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIN  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return op[2];
    endfunction

    // MUL is left out on purpose: the low half of the product does not
    // depend on the operand signs.
    function automatic logic rs1_is_signed(input mdu_op_e op);
        return (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
    endfunction

    function automatic logic rs2_is_signed(input mdu_op_e op);
        return (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
//   Request/response bundle between the EX stage and the multiply/divide unit.
//   master (pipeline): drives start, func3, rs1, rs2, flush; observes busy, done, result.
//   slave  (unit)    : the reverse.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, func3, rs1, rs2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, func3, rs1, rs2, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit_iter_core.sv
// muldiv_iter_core
//   Radix-2 datapath of the multiply/divide unit. One {hi, lo} register pair
//   serves both operations: shift-add multiply leaves the product in {hi, lo};
//   restoring division leaves the remainder in hi and the quotient in lo.
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     load_i           load hi_i / lo_i / b_i (takes priority over step_i)
//     step_i           perform one iteration
//     is_div_i         1: shift-subtract step, 0: shift-add step
//     hi_i, lo_i, b_i  initial hi/lo and multiplicand/divisor magnitude
//     hi_o, lo_o       current hi/lo contents
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [XLEN:0]   sum;         // hi + (multiplier bit ? b : 0), with carry
    logic [XLEN:0]   shifted_hi;  // partial remainder after the left shift
    logic [XLEN:0]   trial;       // shifted_hi - divisor; MSB set means borrow

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        hi_d       = hi_q;
        lo_d       = lo_q;
        b_d        = b_q;
        sum        = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted_hi = {hi_q, lo_q[XLEN-1]};
        trial      = shifted_hi - {1'b0, b_q};

        if (load_i) begin
            hi_d = hi_i;
            lo_d = lo_i;
            b_d  = b_i;
        end else if (step_i) begin
            if (is_div_i) begin
                // Restoring step: keep the difference only when it did not borrow.
                if (!trial[XLEN]) begin
                    hi_d = trial[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = shifted_hi[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                // The multiplier drains out of lo as the product shifts in.
                {hi_d, lo_d} = {sum, lo_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset too; they are few, and a known
        // value keeps the held result and the simulation free of X.
        if (rst) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide unit. Accepts one op from IDLE, iterates
//   XLEN cycles in CALC (or skips straight to FIN for divide-by-zero and signed
//   overflow), sign-corrects in FIN and returns a registered result with a
//   one-cycle done pulse.
//   Ports:
//     clk   clock
//     rst   synchronous active-high reset
//     bus   muldiv_unit_if slave: start/func3/rs1/rs2/flush in,
//           busy/done/result out (all outputs come from registers)
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e      state_q, state_d;
    mdu_op_e         op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            neg_q, neg_d;       // negate product / quotient in FIN
    logic            rem_neg_q, rem_neg_d; // negate remainder in FIN
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            core_load, core_step;
    logic [XLEN-1:0] core_hi_init, core_lo_init;
    logic [XLEN-1:0] core_hi, core_lo;

    // Operand decode, evaluated while IDLE.
    mdu_op_e           f3;
    logic              a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    assign f3       = mdu_op_e'(bus.func3);
    assign a_neg    = rs1_is_signed(f3) & bus.rs1[XLEN-1];
    assign b_neg    = rs2_is_signed(f3) & bus.rs2[XLEN-1];
    assign mag_a    = a_neg ? -bus.rs1 : bus.rs1;
    assign mag_b    = b_neg ? -bus.rs2 : bus.rs2;
    assign div_zero = op_is_div(f3) && (bus.rs2 == '0);
    assign div_ovf  = ((f3 == F3_DIV) || (f3 == F3_REM)) && (bus.rs1 == INT_MIN) && (bus.rs2 == '1);

    assign prod_fix = neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};
    assign quo_fix  = neg_q ? -core_lo : core_lo;
    assign rem_fix  = rem_neg_q ? -core_hi : core_hi;

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load_i   (core_load),
        .step_i   (core_step),
        .is_div_i (op_is_div(op_q)),
        .hi_i     (core_hi_init),
        .lo_i     (core_lo_init),
        .b_i      (mag_b),
        .hi_o     (core_hi),
        .lo_o     (core_lo)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        neg_d        = neg_q;
        rem_neg_d    = rem_neg_q;
        done_d       = 1'b0;
        result_d     = result_q;
        core_load    = 1'b0;
        core_step    = 1'b0;
        core_hi_init = '0;
        core_lo_init = mag_a;

        if (bus.flush) begin
            state_d = MDU_IDLE;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (bus.start) begin
                        op_d      = f3;
                        cnt_d     = '0;
                        core_load = 1'b1;
                        if (div_zero || div_ovf) begin
                            // Preload the final {remainder, quotient}; no sign fix-up.
                            core_hi_init = div_zero ? bus.rs1 : '0;
                            core_lo_init = div_zero ? '1 : bus.rs1;
                            neg_d        = 1'b0;
                            rem_neg_d    = 1'b0;
                            state_d      = MDU_FIN;
                        end else begin
                            neg_d     = a_neg ^ b_neg;
                            rem_neg_d = a_neg;
                            state_d   = MDU_CALC;
                        end
                    end
                end
                MDU_CALC: begin
                    core_step = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = MDU_FIN;
                end
                MDU_FIN: begin
                    case (op_q)
                        F3_MUL:                        result_d = prod_fix[XLEN-1:0];
                        F3_MULH, F3_MULHSU, F3_MULHU:  result_d = prod_fix[2*XLEN-1:XLEN];
                        F3_DIV, F3_DIVU:               result_d = quo_fix;
                        F3_REM, F3_REMU:               result_d = rem_fix;
                    endcase
                    done_d  = 1'b1;
                    state_d = MDU_IDLE;
                end
                default: state_d = MDU_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MDU_IDLE;
            op_q      <= F3_MUL;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign bus.busy   = (state_q != MDU_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit (XLEN = 32). Expected results come from
//   a 64-bit arithmetic model of the RV32M rules; expected busy/done timing comes
//   from the latency rules (XLEN+2 cycles normally, 2 on the fast path).
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] MIN_V = 32'h8000_0000;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [XLEN-1:0] hold_res;  // value result must show while no done is due

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_result(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] sa, sb, ua, ub, p;
        sa = {{XLEN{a[XLEN-1]}}, a};
        sb = {{XLEN{b[XLEN-1]}}, b};
        ua = {{XLEN{1'b0}}, a};
        ub = {{XLEN{1'b0}}, b};
        case (op)
            3'd0: begin p = ua * ub; return p[XLEN-1:0]; end
            3'd1: begin p = sa * sb; return p[2*XLEN-1:XLEN]; end
            3'd2: begin p = sa * ub; return p[2*XLEN-1:XLEN]; end
            3'd3: begin p = ua * ub; return p[2*XLEN-1:XLEN]; end
            3'd4: begin
                if (b == '0) return '1;
                if (a == MIN_V && b == '1) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == '0) ? '1 : a / b;
            3'd6: begin
                if (b == '0) return a;
                if (a == MIN_V && b == '1) return '0;
                return $signed(a) % $signed(b);
            end
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    function automatic bit ref_fast(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return op[2] && ((b == '0) || (!op[0] && a == MIN_V && b == '1));
    endfunction

    // Issues one op and checks busy/done/result every cycle up to the expected
    // done cycle. b2b: issue in the current cycle (the previous op's done cycle).
    // poke_kind at poke_cyc: 1 = spurious start with other operands,
    // 2 = flush, 3 = reset.
    task automatic do_op(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input bit b2b, input int poke_cyc, input int poke_kind);
        logic [XLEN-1:0] exp_res;
        int lat;
        bit aborted;
        exp_res = ref_result(op, a, b);
        lat     = ref_fast(op, a, b) ? 2 : XLEN + 2;
        aborted = 1'b0;
        if (!b2b) @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = op;
        bus.rs1   = a;
        bus.rs2   = b;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (aborted) begin
                check($sformatf("abort_busy op%0d c%0d", op, c), {31'b0, bus.busy}, 32'd0);
                check($sformatf("abort_done op%0d c%0d", op, c), {31'b0, bus.done}, 32'd0);
                check($sformatf("abort_res op%0d c%0d", op, c), bus.result, hold_res);
            end else begin
                check($sformatf("busy op%0d c%0d", op, c), {31'b0, bus.busy}, {31'b0, c < lat});
                check($sformatf("done op%0d c%0d", op, c), {31'b0, bus.done}, {31'b0, c == lat});
                if (c == lat) hold_res = exp_res;
                check($sformatf("result op%0d a=%h b=%h c%0d", op, a, b, c), bus.result, hold_res);
            end
            bus.start = 1'b0;
            bus.flush = 1'b0;
            rst       = 1'b0;
            bus.func3 = op;
            bus.rs1   = a;
            bus.rs2   = b;
            if (c == poke_cyc) begin
                case (poke_kind)
                    1: begin
                        bus.start = 1'b1;
                        bus.func3 = 3'd4;
                        bus.rs1   = ~a;
                        bus.rs2   = '0;
                    end
                    2: begin bus.flush = 1'b1; aborted = 1'b1; end
                    3: begin rst = 1'b1; aborted = 1'b1; hold_res = '0; end
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        logic [2:0]      r_op;
        logic [XLEN-1:0] r_a, r_b;
        int              kind;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.func3 = '0;
        bus.rs1   = '0;
        bus.rs2   = '0;
        hold_res  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        rst = 1'b0;

        // Directed cases.
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 0, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0);
        do_op(3'd1, MIN_V, MIN_V, 1'b0, 0, 0);
        do_op(3'd4, -32'sd7, 32'd2, 1'b0, 0, 0);
        do_op(3'd6, -32'sd7, 32'd2, 1'b0, 0, 0);
        do_op(3'd5, 32'd100, 32'd7, 1'b0, 0, 0);
        do_op(3'd7, 32'd100, 32'd7, 1'b0, 0, 0);
        do_op(3'd5, 32'd5, 32'd0, 1'b0, 0, 0);
        do_op(3'd6, 32'd5, 32'd0, 1'b0, 0, 0);
        do_op(3'd4, MIN_V, 32'hFFFF_FFFF, 1'b0, 0, 0);
        do_op(3'd6, MIN_V, 32'hFFFF_FFFF, 1'b0, 0, 0);

        // Start while busy is ignored; then a start in the done cycle is taken.
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 5, 1);
        do_op(3'd5, 32'd1000, 32'd9, 1'b1, 0, 0);
        do_op(3'd6, 32'd77, 32'd0, 1'b1, 0, 0);
        do_op(3'd1, 32'h1234_5678, 32'h8765_4321, 1'b1, 0, 0);

        // Abort by flush keeps the old result; abort by reset clears it.
        do_op(3'd3, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 10, 2);
        do_op(3'd4, 32'h7FFF_0000, 32'd3, 1'b0, 0, 0);
        do_op(3'd3, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 10, 3);
        do_op(3'd7, 32'hFFFF_FFF0, 32'd6, 1'b0, 0, 0);

        // Randomised ops with boundary operands mixed in.
        for (int i = 0; i < 60; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            kind = $urandom_range(0, 9);
            case (kind)
                0: r_b = '0;
                1: begin r_a = MIN_V; r_b = '1; end
                2: begin r_a = $urandom_range(0, 300); r_b = $urandom_range(1, 20); end
                3: r_b = -($urandom_range(1, 20));
                default: ;
            endcase
            do_op(r_op, r_a, r_b, 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
